ws_array_ctrl: RTL and testbench

//  Sequencer for the weight-stationary pe_ws systolic array. Per job it runs three phases:
//   1. Preload one weight row per cycle into the array.
//   2. Stream M input vectors from the activation buffer.
//   3. Hold accumulation enabled until the skewed results drain out of the bottom row.

---
 rtl/ws_array_ctrl_if.sv | 35 +++
 rtl/ws_array_ctrl.sv | 148 ++++++++++++++
 tb/tb_ws_array_ctrl.sv | 210 +++++++++++++++++++++
 3 files changed

// File: rtl/ws_array_ctrl_if.sv
// rtl/ws_array_ctrl_if.sv - job, SRAM and array control bundle for the weight-stationary sequencer
interface ws_array_ctrl_if #(
    parameter int ROWS = 4,
    parameter int COLS = 4,
    parameter int AW   = 8,
    parameter int CW   = 9
);
    logic            start_i;
    logic [CW-1:0]   m_len_i;
    logic            busy_o;
    logic            done_o;
    logic            w_rd_en_o;
    logic [AW-1:0]   w_rd_addr_o;
    logic            load_en_o;
    logic [AW-1:0]   w_row_o;
    logic            x_rd_en_o;
    logic [AW-1:0]   x_rd_addr_o;
    logic            acc_en_o;
    logic [ROWS-1:0] row_vld_o;
    logic [COLS-1:0] col_vld_o;

    // Sequencer side: takes the job request, drives SRAM reads and array strobes.
    modport slave (
        input  start_i, m_len_i,
        output busy_o, done_o, w_rd_en_o, w_rd_addr_o, load_en_o, w_row_o,
               x_rd_en_o, x_rd_addr_o, acc_en_o, row_vld_o, col_vld_o
    );

    // Job-issue side.
    modport master (
        output start_i, m_len_i,
        input  busy_o, done_o, w_rd_en_o, w_rd_addr_o, load_en_o, w_row_o,
               x_rd_en_o, x_rd_addr_o, acc_en_o, row_vld_o, col_vld_o
    );
endinterface

// File: rtl/ws_array_ctrl.sv
// rtl/ws_array_ctrl.sv - weight preload / input stream / drain sequencer for the pe_ws array
module ws_array_ctrl #(
    parameter int ROWS  = 4,
    parameter int COLS  = 4,
    parameter int M_MAX = 256,
    parameter int AW    = 8,
    parameter int CW    = 9
) (
    input  logic          clk,
    input  logic          rstn,
    ws_array_ctrl_if.slave bus
);
    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD_W,
        S_STREAM,
        S_DRAIN,
        S_DONE
    } state_t;

    localparam int            DW     = $clog2(ROWS + COLS + 1);
    localparam logic [AW-1:0] W_LAST = AW'(ROWS - 1);
    localparam logic [DW-1:0] D_LAST = DW'(ROWS + COLS - 1);
    localparam logic [CW-1:0] M_SAT  = CW'(M_MAX);

    state_t          state_q;
    logic [CW-1:0]   m_q;
    logic [AW-1:0]   w_addr_q;
    logic [AW-1:0]   x_addr_q;
    logic [DW-1:0]   drain_cnt_q;
    logic            w_rd_en_q;
    logic            x_rd_en_q;
    logic            acc_en_q;
    logic            busy_q;
    logic            done_q;
    logic            load_en_q;
    logic [AW-1:0]   w_row_q;
    logic [ROWS-1:0] row_vld_q;
    logic [COLS-1:0] col_sr_q;

    logic [CW-1:0]   m_sat_d;
    logic            x_last_d;

    // Clamp the requested vector count and spot the final activation address.
    always_comb begin
        m_sat_d  = (bus.m_len_i > M_SAT) ? M_SAT : bus.m_len_i;
        x_last_d = (CW'(x_addr_q) == (m_q - CW'(1)));
    end

    // Job sequencer: all strobes and addresses are registered alongside the state.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q     <= S_IDLE;
            m_q         <= '0;
            w_addr_q    <= '0;
            x_addr_q    <= '0;
            drain_cnt_q <= '0;
            w_rd_en_q   <= 1'b0;
            x_rd_en_q   <= 1'b0;
            acc_en_q    <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (bus.start_i) begin
                        m_q    <= m_sat_d;
                        busy_q <= 1'b1;
                        if (m_sat_d != '0) begin
                            state_q   <= S_LOAD_W;
                            w_rd_en_q <= 1'b1;
                            w_addr_q  <= '0;
                        end else begin
                            // Empty job: skip straight to completion without touching SRAMs.
                            state_q <= S_DONE;
                            done_q  <= 1'b1;
                        end
                    end
                end
                S_LOAD_W: begin
                    if (w_addr_q == W_LAST) begin
                        state_q   <= S_STREAM;
                        w_rd_en_q <= 1'b0;
                        x_rd_en_q <= 1'b1;
                        x_addr_q  <= '0;
                        acc_en_q  <= 1'b1;
                    end else begin
                        w_addr_q <= w_addr_q + AW'(1);
                    end
                end
                S_STREAM: begin
                    if (x_last_d) begin
                        state_q     <= S_DRAIN;
                        x_rd_en_q   <= 1'b0;
                        drain_cnt_q <= '0;
                    end else begin
                        x_addr_q <= x_addr_q + AW'(1);
                    end
                end
                S_DRAIN: begin
                    // Fixed window covering the row and column skew of the last vector.
                    if (drain_cnt_q == D_LAST) begin
                        state_q  <= S_DONE;
                        acc_en_q <= 1'b0;
                        done_q   <= 1'b1;
                    end else begin
                        drain_cnt_q <= drain_cnt_q + DW'(1);
                    end
                end
                S_DONE: begin
                    state_q <= S_IDLE;
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    // Free-running skew pipes: weight-load delay, per-row input skew, per-column output skew.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            load_en_q <= 1'b0;
            w_row_q   <= '0;
            row_vld_q <= '0;
            col_sr_q  <= '0;
        end else begin
            load_en_q <= w_rd_en_q;
            w_row_q   <= w_addr_q;
            row_vld_q <= {row_vld_q[ROWS-2:0], x_rd_en_q};
            col_sr_q  <= {col_sr_q[COLS-2:0], row_vld_q[ROWS-1]};
        end
    end

    assign bus.busy_o      = busy_q;
    assign bus.done_o      = done_q;
    assign bus.w_rd_en_o   = w_rd_en_q;
    assign bus.w_rd_addr_o = w_addr_q;
    assign bus.load_en_o   = load_en_q;
    assign bus.w_row_o     = w_row_q;
    assign bus.x_rd_en_o   = x_rd_en_q;
    assign bus.x_rd_addr_o = x_addr_q;
    assign bus.acc_en_o    = acc_en_q;
    assign bus.row_vld_o   = row_vld_q;
    assign bus.col_vld_o   = col_sr_q;
endmodule

// File: tb/tb_ws_array_ctrl.sv
// tb/tb_ws_array_ctrl.sv - self-checking bench for ws_array_ctrl
module tb_ws_array_ctrl;
    localparam int R     = 4;
    localparam int C     = 4;
    localparam int M_MAX = 256;
    localparam int AW    = 8;
    localparam int CW    = 9;

    logic clk;
    logic rstn;
    int   checks;
    int   errors;

    ws_array_ctrl_if #(.ROWS(R), .COLS(C), .AW(AW), .CW(CW)) bus ();

    ws_array_ctrl #(.ROWS(R), .COLS(C), .M_MAX(M_MAX), .AW(AW), .CW(CW)) dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int m_len;
        int exp_reads;
        int exp_last;
        int exp_done_rel;
    } vec_t;

    function automatic logic in_rng(input int r, input int lo, input int hi);
        return (r >= lo) && (r <= hi);
    endfunction

    // Expected {busy, done, w_rd_en, load_en, x_rd_en, acc_en, row_vld[3:0], col_vld[3:0]}
    // at cycle r of a job with m vectors, straight from the phase timeline.
    function automatic logic [13:0] exp_ctrl(input int r, input int m);
        logic [R-1:0] rv;
        logic [C-1:0] cv;
        int           e;
        if (m == 0) return (r == 1) ? 14'b11_0000_0000_0000 : 14'b0;
        e = 2 * R + m + C + 1;
        for (int i = 0; i < R; i++) rv[i] = in_rng(r, R + 2 + i, R + m + 1 + i);
        for (int i = 0; i < C; i++) cv[i] = in_rng(r, 2 * R + 2 + i, 2 * R + m + 1 + i);
        return {in_rng(r, 1, e), 1'(r == e), in_rng(r, 1, R), in_rng(r, 2, R + 1),
                in_rng(r, R + 1, R + m), in_rng(r, R + 1, e - 1), rv, cv};
    endfunction

    function automatic logic [13:0] act_ctrl();
        return {bus.busy_o, bus.done_o, bus.w_rd_en_o, bus.load_en_o, bus.x_rd_en_o,
                bus.acc_en_o, bus.row_vld_o, bus.col_vld_o};
    endfunction

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s @%0t: got 0x%0h expected 0x%0h", name, $time, act, exp);
        end
    endtask

    // Reference model: a job is just (acceptance cycle, clamped length); every output
    // is a function of the cycles elapsed since acceptance.
    bit job_on;
    int rel;
    int job_m;
    always @(negedge clk) begin
        logic [13:0] e;
        if (!rstn) begin
            job_on = 1'b0;
            check("reset_outputs", {act_ctrl(), bus.w_rd_addr_o, bus.w_row_o, bus.x_rd_addr_o}, 0);
        end else begin
            if (job_on) begin
                rel++;
                if (rel > ((job_m == 0) ? 1 : 2 * R + job_m + C + 1)) job_on = 1'b0;
            end
            e = job_on ? exp_ctrl(rel, job_m) : 14'b0;
            check("ctrl_bits", act_ctrl(), e);
            if (e[11]) check("w_rd_addr", bus.w_rd_addr_o, rel - 1);
            if (e[10]) check("w_row", bus.w_row_o, rel - 2);
            if (e[9])  check("x_rd_addr", bus.x_rd_addr_o, rel - R - 1);
            if (!e[13] && bus.start_i) begin
                job_on = 1'b1;
                rel    = 0;
                job_m  = (int'(bus.m_len_i) > M_MAX) ? M_MAX : int'(bus.m_len_i);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (bus.busy_o && n < 600) begin
            tick();
            n++;
        end
        if (bus.busy_o) check("idle_timeout", 1, 0);
    endtask

    vec_t vecs[6];

    initial begin
        checks = 0;
        errors = 0;
        job_on = 1'b0;
        rel    = 0;
        job_m  = 0;
        vecs[0] = '{3, 3, 2, 16};
        vecs[1] = '{0, 0, 0, 1};
        vecs[2] = '{1, 1, 0, 14};
        vecs[3] = '{17, 17, 16, 30};
        vecs[4] = '{256, 256, 255, 269};
        vecs[5] = '{261, 256, 255, 269};

        rstn        = 1'b0;
        bus.start_i = 1'b0;
        bus.m_len_i = '0;
        repeat (3) @(posedge clk);
        #1 rstn = 1'b1;
        tick();

        // Table-driven jobs: read count, last activation address, done latency.
        foreach (vecs[k]) begin
            int reads;
            int last;
            int done_rel;
            wait_idle();
            bus.m_len_i = CW'(vecs[k].m_len);
            bus.start_i = 1'b1;
            tick();
            bus.start_i = 1'b0;
            bus.m_len_i = CW'($urandom_range(0, 511));
            reads    = 0;
            last     = 0;
            done_rel = -1;
            for (int c = 1; c <= 400 && done_rel < 0; c++) begin
                @(negedge clk);
                if (bus.x_rd_en_o) begin
                    reads++;
                    last = int'(bus.x_rd_addr_o);
                end
                if (bus.done_o) done_rel = c;
                tick();
            end
            check("vec_reads", reads, vecs[k].exp_reads);
            check("vec_last_addr", last, vecs[k].exp_last);
            check("vec_done_cycle", done_rel, vecs[k].exp_done_rel);
        end

        // Starts at cycle 3 (busy) and 16 (DONE) ignored; held into cycle 17 it is taken.
        wait_idle();
        bus.m_len_i = CW'(3);
        bus.start_i = 1'b1;
        tick();
        bus.start_i = 1'b0;
        repeat (2) tick();
        bus.start_i = 1'b1;
        bus.m_len_i = CW'(7);
        tick();
        bus.start_i = 1'b0;
        repeat (12) tick();
        check("t4_done_at_16", bus.done_o, 1);
        bus.start_i = 1'b1;
        bus.m_len_i = CW'(5);
        tick();
        check("t4_idle_at_17", bus.busy_o, 0);
        tick();
        bus.start_i = 1'b0;
        check("t4_new_job_at_18", {bus.busy_o, bus.w_rd_en_o, bus.w_rd_addr_o}, {2'b11, 8'd0});

        // Asynchronous reset in the middle of STREAM.
        wait_idle();
        bus.m_len_i = CW'(3);
        bus.start_i = 1'b1;
        tick();
        bus.start_i = 1'b0;
        repeat (5) tick();
        check("t5_streaming", bus.x_rd_en_o, 1);
        #1 rstn = 1'b0;
        #1 check("t5_async_clear", {act_ctrl(), bus.w_rd_addr_o, bus.w_row_o, bus.x_rd_addr_o}, 0);
        tick();
        rstn = 1'b1;
        tick();

        // Random start pulses, lengths and occasional resets against the model.
        for (int i = 0; i < 1500; i++) begin
            bus.start_i = ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 7) == 0) bus.m_len_i = CW'($urandom_range(240, 300));
            else bus.m_len_i = CW'($urandom_range(0, 20));
            if ($urandom_range(0, 299) == 0) begin
                #1 rstn = 1'b0;
                tick();
                rstn = 1'b1;
            end
            tick();
        end
        bus.start_i = 1'b0;
        wait_idle();
        repeat (3) tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
